// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: synchronizes the raw interrupt lines, keeps the mip pending view
// and presents one locked, prioritized request to the core interrupt controller.
module riscv_irq_arbiter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [14:0] FAST_EDGE_MASK = 15'h0000,
  parameter logic [14:0] FAST_SEC_MASK  = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic [17:0] mie_i,
  input  logic [17:0] mip_clr_i,
  input  logic        irq_ack_i,
  input  logic        irq_kill_i,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_sec_o,
  output logic [17:0] mip_o
);

  localparam int unsigned NUM_SRC  = 18;
  localparam int unsigned NUM_FAST = 15;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned ID_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  state_e                              r_state;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_FAST-1:0]                 r_s_d;
  logic [NUM_SRC-1:0]                  r_pend;
  logic                                r_irq;
  logic [ID_W-1:0]                     r_id;
  logic                                r_sec;
  logic [IDX_W-1:0]                    r_lock_idx;

  logic [NUM_SRC-1:0]  w_raw;
  logic [NUM_SRC-1:0]  w_s;
  logic [NUM_SRC-1:0]  w_en;
  logic [NUM_SRC-1:0]  w_pend_nxt;
  logic [NUM_SRC-1:0]  w_ack_onehot;
  logic [NUM_FAST-1:0] w_clr;
  logic                w_ack_take;
  logic                w_lock_live;
  logic                w_sel_valid;
  logic [IDX_W-1:0]    w_sel_idx;
  logic [5:0]          w_unused;

  // Bit order matches mie/mip: [17] sw, [16] timer, [15] ext, [14:0] fast.
  assign w_raw = {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
  assign w_s   = r_sync[SYNC_STAGES-1];

  function automatic logic [ID_W-1:0] f_src_id(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(17): return ID_W'(3);
      IDX_W'(16): return ID_W'(7);
      IDX_W'(15): return ID_W'(11);
      default:    return ID_W'(idx) + ID_W'(16);
    endcase
  endfunction

  function automatic logic f_src_sec(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(NUM_FAST)) return FAST_SEC_MASK[idx[3:0]];
    return 1'b0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d  <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_s_d <= w_s[NUM_FAST-1:0];
    end
  end

  // Acknowledge clears only the locked source's edge-latched pending bit.
  assign w_ack_take   = (r_state == ST_REQ) && irq_ack_i;
  assign w_ack_onehot = NUM_SRC'(1) << r_lock_idx;
  assign w_clr        = mip_clr_i[NUM_FAST-1:0] |
                        (w_ack_take ? w_ack_onehot[NUM_FAST-1:0] : '0);
  assign w_unused     = {mip_clr_i[NUM_SRC-1:NUM_FAST], w_ack_onehot[NUM_SRC-1:NUM_FAST]};

  // A fresh rising edge wins over a clear arriving in the same cycle.
  always_comb begin
    w_pend_nxt = w_s;
    for (int k = 0; k < NUM_FAST; k++) begin
      if (FAST_EDGE_MASK[k]) begin
        w_pend_nxt[k] = (r_pend[k] & ~w_clr[k]) | (w_s[k] & ~r_s_d[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  // Later assignments win: timer < sw < ext < fast[0] < ... < fast[14].
  assign w_en = r_pend & mie_i;
  always_comb begin
    w_sel_valid = |w_en;
    w_sel_idx   = '0;
    if (w_en[16]) w_sel_idx = IDX_W'(16);
    if (w_en[17]) w_sel_idx = IDX_W'(17);
    if (w_en[15]) w_sel_idx = IDX_W'(15);
    for (int k = 0; k < NUM_FAST; k++) begin
      if (w_en[k]) w_sel_idx = IDX_W'(k);
    end
  end

  assign w_lock_live = r_pend[r_lock_idx] & mie_i[r_lock_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_irq      <= 1'b0;
      r_id       <= '0;
      r_sec      <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_state    <= ST_REQ;
            r_irq      <= 1'b1;
            r_id       <= f_src_id(w_sel_idx);
            r_sec      <= f_src_sec(w_sel_idx);
            r_lock_idx <= w_sel_idx;
          end
        end
        ST_REQ: begin
          if (irq_ack_i) begin
            r_state <= ST_HOLDOFF;
            r_irq   <= 1'b0;
          end else if (irq_kill_i || !w_lock_live) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
          end
        end
        ST_HOLDOFF: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o     = r_irq;
  assign irq_id_o  = r_id;
  assign irq_sec_o = r_sec;
  assign mip_o     = r_pend;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Scoreboard bench for riscv_irq_arbiter: a behavioural model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_riscv_irq_arbiter;

  localparam int unsigned SS       = 2;
  localparam logic [14:0] EDGE_M   = 15'h0025;
  localparam logic [14:0] SEC_M    = 15'h0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw, tmr, ext;
  logic [14:0] fast;
  logic [17:0] mie, clr;
  logic        ack, kill;
  logic        o_irq;
  logic [4:0]  o_id;
  logic        o_sec;
  logic [17:0] o_mip;

  riscv_irq_arbiter #(
    .SYNC_STAGES   (SS),
    .FAST_EDGE_MASK(EDGE_M),
    .FAST_SEC_MASK (SEC_M)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_software_i(sw),
    .irq_timer_i   (tmr),
    .irq_external_i(ext),
    .irq_fast_i    (fast),
    .mie_i         (mie),
    .mip_clr_i     (clr),
    .irq_ack_i     (ack),
    .irq_kill_i    (kill),
    .irq_o         (o_irq),
    .irq_id_o      (o_id),
    .irq_sec_o     (o_sec),
    .mip_o         (o_mip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        irq;
    logic [4:0]  id;
    logic        sec;
    logic [17:0] mip;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: raw-sample history, pending set, and request state.
  logic [17:0] m_hist[SS+1];
  logic [17:0] m_pend;
  int          m_st;      // 0 idle, 1 request outstanding, 2 holdoff
  int          m_id;
  logic        m_irq;
  logic        m_sec;

  function automatic int bit_of(input int id);
    if (id == 3)  return 17;
    if (id == 7)  return 16;
    if (id == 11) return 15;
    return id - 16;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= SS; i++) m_hist[i] = '0;
    m_pend = '0;
    m_st   = 0;
    m_id   = 0;
    m_irq  = 1'b0;
    m_sec  = 1'b0;
  endtask

  task automatic model_step();
    logic [17:0] raw, s, sd, np;
    logic        took;
    int          sel;
    exp_t        e;
    raw  = {sw, tmr, ext, fast};
    s    = m_hist[SS-1];
    sd   = m_hist[SS];
    took = (m_st == 1) && ack;
    for (int b = 0; b < 18; b++) begin
      if (b < 15 && EDGE_M[b]) begin
        np[b] = (m_pend[b] && !(clr[b] || (took && bit_of(m_id) == b))) || (s[b] && !sd[b]);
      end else begin
        np[b] = s[b];
      end
    end
    if (m_st == 0) begin
      sel = -1;
      for (int k = 14; k >= 0; k--) if (sel < 0 && m_pend[k] && mie[k]) sel = 16 + k;
      if (sel < 0 && m_pend[15] && mie[15]) sel = 11;
      if (sel < 0 && m_pend[17] && mie[17]) sel = 3;
      if (sel < 0 && m_pend[16] && mie[16]) sel = 7;
      if (sel >= 0) begin
        m_st  = 1;
        m_irq = 1'b1;
        m_id  = sel;
        m_sec = (sel >= 16) ? SEC_M[sel-16] : 1'b0;
      end
    end else if (m_st == 1) begin
      if (took) begin
        m_st = 2; m_irq = 1'b0;
      end else if (kill || !(m_pend[bit_of(m_id)] && mie[bit_of(m_id)])) begin
        m_st = 0; m_irq = 1'b0;
      end
    end else begin
      m_st = 0;
    end
    m_pend = np;
    for (int i = SS; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = raw;
    e.cyc = cyc + 1;
    e.irq = m_irq;
    e.id  = 5'(m_id);
    e.sec = m_sec;
    e.mip = m_pend;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (e.cyc != cyc || {o_irq, o_id, o_sec, o_mip} !== {e.irq, e.id, e.sec, e.mip}) begin
        n_err++;
        $display("FAIL scoreboard cyc=%0d (exp cyc %0d): got irq=%b id=%0d sec=%b mip=%h, want irq=%b id=%0d sec=%b mip=%h",
                 cyc, e.cyc, o_irq, o_id, o_sec, o_mip, e.irq, e.id, e.sec, e.mip);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    sw = 0; tmr = 0; ext = 0; fast = '0;
    mie = '0; clr = '0; ack = 0; kill = 0;
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({o_irq, o_id, o_sec, o_mip} !== 25'd0) begin
      n_err++;
      $display("FAIL %s: got irq=%b id=%0d sec=%b mip=%h, want all zero", name, o_irq, o_id, o_sec, o_mip);
    end
  endtask

  task automatic wait_req(input int max);
    int k = 0;
    while (!m_irq && k < max) begin tick(); k++; end
    if (!m_irq) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: no request within %0d cycles, want irq=1", max);
    end
  endtask

  task automatic pulse_ack();
    ack = 1; tick(); ack = 0;
  endtask

  // Async reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    #3 rst_n = 0;
    #1 check_zero("async_reset");
    clear_inputs();
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    rst_n = 1;

    // Edge fast[2]: one-cycle pulse, request, ack, holdoff.
    mie = 18'h00004;
    fast[2] = 1; tick(); fast[2] = 0;
    wait_req(10); ticks(3); pulse_ack(); ticks(4);

    // Level timer + ext, then withdraw ext.
    mie = 18'h18000; tmr = 1; ext = 1;
    wait_req(10); ticks(2);
    ext = 0; ticks(6);
    // Higher-priority fast[14] while timer is locked.
    mie = 18'h1C000; fast[14] = 1; ticks(5);
    pulse_ack(); ticks(6);
    tmr = 0; fast[14] = 0; pulse_ack(); ticks(6);

    // Kill on edge fast[0], then reissue and ack.
    mie = 18'h00001;
    fast[0] = 1; tick(); fast[0] = 0;
    wait_req(10); tick();
    kill = 1; tick(); kill = 0;
    wait_req(10); tick(); pulse_ack(); ticks(4);

    // fast[5] edge: clear coincident with a new edge, then clear alone.
    mie = '0;
    fast[5] = 1; tick(); fast[5] = 0; ticks(4);
    fast[5] = 1; tick(); fast[5] = 0; tick();
    clr[5] = 1; tick(); clr[5] = 0; ticks(3);
    clr[5] = 1; tick(); clr[5] = 0;
    mie = 18'h00020; ticks(4);

    // Secure fast[3], then reset mid-request.
    mie = 18'h00008; fast[3] = 1;
    wait_req(10); ticks(2);
    async_reset();
    ticks(3);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [17:0] flip;
      for (int b = 0; b < 18; b++) flip[b] = ($urandom_range(0, 15) == 0);
      {sw, tmr, ext, fast} = {sw, tmr, ext, fast} ^ flip;
      if ($urandom_range(0, 63) == 0) mie = 18'($urandom) | (($urandom_range(0, 1) == 0) ? 18'h3FFFF : 18'h0);
      ack  = (m_irq && $urandom_range(0, 3) == 0) || ($urandom_range(0, 31) == 0);
      kill = (m_irq && $urandom_range(0, 19) == 0) || ($urandom_range(0, 63) == 0);
      clr  = ($urandom_range(0, 15) == 0) ? 18'(18'd1 << $urandom_range(0, 17)) : 18'd0;
      tick();
      if (c == 1000 || c == 2200) async_reset();
    end
    clear_inputs();
    ticks(4);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
